// File: rtl/osd_wr_scheduler.sv
// osd_wr_scheduler
//   Queues OSD write commands from the resynchronised write stream and drives
//   the single-port OSD text RAM. Renderer reads always own the address port;
//   queued writes (single writes and expanded fills) use only the idle slots,
//   optionally only during vertical blanking.
//
// Ports
//   VCLK, nVRST        clock, async active-low reset
//   in_valid/in_ready  command handshake (in_ready = ~full, registered)
//   in_vec[24:0]       {ctrl[1:0], addr[9:0], data[12:0]}
//                      ctrl 00 no-op, 01/11 write, 10 fill addr..FILL_END
//   rd_en, rd_addr     renderer read request (highest priority)
//   wr_blank_only      1: writes only while vblank=1
//   vblank             vertical blanking, VCLK-synchronous
//   ram_addr/we/wdata  registered RAM port
//   busy               queue non-empty or fill in progress
//   fill_active        fill state machine in FILL
//   q_level            queue occupancy after the last edge
module osd_wr_scheduler #(
    parameter int          QDEPTH_LOG2 = 2,
    parameter logic [9:0]  FILL_END    = 10'h3FF
) (
    input  logic                   VCLK,
    input  logic                   nVRST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [24:0]            in_vec,
    input  logic                   rd_en,
    input  logic [9:0]             rd_addr,
    input  logic                   wr_blank_only,
    input  logic                   vblank,
    output logic [9:0]             ram_addr,
    output logic                   ram_we,
    output logic [12:0]            ram_wdata,
    output logic                   busy,
    output logic                   fill_active,
    output logic [QDEPTH_LOG2:0]   q_level
);

    localparam int                   DEPTH    = 1 << QDEPTH_LOG2;
    localparam logic [QDEPTH_LOG2:0] FULL_CNT = (QDEPTH_LOG2+1)'(DEPTH);

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [9:0]  addr;
        logic [12:0] data;
    } cmd_t;

    typedef enum logic {IDLE, FILL} state_t;

    cmd_t                   mem [DEPTH];
    logic [QDEPTH_LOG2-1:0] wptr, rptr;
    logic [QDEPTH_LOG2:0]   count, count_nxt;
    logic                   rdy;
    cmd_t                   head;

    state_t                 state, state_d;
    logic [9:0]             fill_ptr, fill_ptr_d;

    logic                   push, pop, wr_slot, wr_issue;
    logic [9:0]             wr_addr;
    logic [12:0]            wr_data;

    assign head        = mem[rptr];
    assign in_ready    = rdy;
    assign push        = in_valid & rdy;
    assign wr_slot     = ~rd_en & (~wr_blank_only | vblank);
    assign fill_active = (state == FILL);
    assign busy        = (count != '0) | fill_active;
    assign q_level     = count;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Next-state / issue logic. A fill stays at the queue head until its
    // last write so the fill data remains readable from the FIFO.
    always_comb begin
        state_d    = state;
        fill_ptr_d = fill_ptr;
        pop        = 1'b0;
        wr_issue   = 1'b0;
        wr_addr    = head.addr;
        wr_data    = head.data;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    if (head.ctrl == 2'b10) begin
                        // entry cycle: latch start, no write yet
                        state_d    = FILL;
                        fill_ptr_d = head.addr;
                    end else if (head.ctrl == 2'b00) begin
                        pop = 1'b1;            // no-op needs no RAM slot
                    end else if (wr_slot) begin
                        pop      = 1'b1;
                        wr_issue = 1'b1;       // 01 and reserved 11
                    end
                end
            end
            FILL: begin
                if (wr_slot) begin
                    wr_issue = 1'b1;
                    wr_addr  = fill_ptr;
                    // >= also terminates a start beyond FILL_END after one write
                    if (fill_ptr >= FILL_END) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fill_ptr_d = fill_ptr + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue storage carries no reset; pointers and count define validity.
    always_ff @(posedge VCLK) begin
        if (push) mem[wptr] <= cmd_t'(in_vec);
    end

    always_ff @(posedge VCLK or negedge nVRST) begin
        if (!nVRST) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rdy      <= 1'b0;
            state    <= IDLE;
            fill_ptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count    <= count_nxt;
            // ready is taken from the settled count only, so a pop while
            // full never opens a same-cycle push
            rdy      <= (count_nxt != FULL_CNT);
            state    <= state_d;
            fill_ptr <= fill_ptr_d;
        end
    end

    always_ff @(posedge VCLK or negedge nVRST) begin
        if (!nVRST) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (rd_en) begin
            ram_addr  <= rd_addr;
            ram_we    <= 1'b0;
        end else if (wr_issue) begin
            ram_addr  <= wr_addr;
            ram_wdata <= wr_data;
            ram_we    <= 1'b1;
        end else begin
            ram_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_osd_wr_scheduler.sv
// Bench for osd_wr_scheduler: directed timing scenarios followed by a
// randomized run checked against a write scoreboard built by expanding each
// accepted command into the ordered list of RAM writes it must produce.
module tb_osd_wr_scheduler;

    logic        VCLK = 1'b0;
    logic        nVRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] in_vec = '0;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        wr_blank_only = 1'b0;
    logic        vblank = 1'b0;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [12:0] ram_wdata;
    logic        busy;
    logic        fill_active;
    logic [2:0]  q_level;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [9:0]  a;
        logic [12:0] d;
    } wr_t;

    osd_wr_scheduler dut (
        .VCLK(VCLK), .nVRST(nVRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_blank_only(wr_blank_only), .vblank(vblank),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .busy(busy), .fill_active(fill_active), .q_level(q_level)
    );

    always #5 VCLK = ~VCLK;

    // advance one active edge, then settle away from it
    task automatic tick;
        @(posedge VCLK);
        #1;
    endtask

    task automatic test_reset;
        nVRST = 1'b0;
        #12;
        n_chk++;
        if ({in_ready, ram_we, busy, fill_active, q_level, ram_addr, ram_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got rdy=%0b we=%0b busy=%0b fa=%0b lvl=%0d addr=%h wd=%h want all 0",
                     in_ready, ram_we, busy, fill_active, q_level, ram_addr, ram_wdata);
        end
        tick;
        nVRST = 1'b1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_before_edge got %0b want 0", in_ready);
        end
        tick;
        n_chk++;
        if ({in_ready, q_level} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL reset_ready_after_edge got rdy=%0b lvl=%0d want rdy=1 lvl=0", in_ready, q_level);
        end
    endtask

    task automatic test_single;
        in_valid = 1'b1;
        in_vec   = {2'b01, 10'h005, 13'h0ABC};
        tick;
        in_valid = 1'b0;
        n_chk++;
        if ({ram_we, busy, q_level} !== {1'b0, 1'b1, 3'd1}) begin
            n_fail++; $display("FAIL single_push got we=%0b busy=%0b lvl=%0d want we=0 busy=1 lvl=1", ram_we, busy, q_level);
        end
        tick;
        n_chk++;
        if ({ram_we, ram_addr, ram_wdata, busy} !== {1'b1, 10'h005, 13'h0ABC, 1'b0}) begin
            n_fail++; $display("FAIL single_write got we=%0b addr=%h wd=%h busy=%0b want we=1 addr=005 wd=0abc busy=0",
                               ram_we, ram_addr, ram_wdata, busy);
        end
        tick;
        n_chk++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL single_one_cycle got we=%0b want 0", ram_we);
        end
    endtask

    task automatic test_backpressure;
        logic [9:0] ra;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_vec   = {2'b01, 10'h020 + 10'(i), 13'h0100 + 13'(i)};
            ra       = 10'($urandom);
            rd_addr  = ra;
            tick;
            n_chk++;
            if ({ram_we, ram_addr} !== {1'b0, ra}) begin
                n_fail++; $display("FAIL bp_read_pass got we=%0b addr=%h want we=0 addr=%h", ram_we, ram_addr, ra);
            end
        end
        in_valid = 1'b0;
        n_chk++;
        if ({in_ready, q_level} !== {1'b0, 3'd4}) begin
            n_fail++; $display("FAIL bp_full got rdy=%0b lvl=%0d want rdy=0 lvl=4", in_ready, q_level);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_chk++;
            if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h020 + 10'(i), 13'h0100 + 13'(i)}) begin
                n_fail++; $display("FAIL bp_drain%0d got we=%0b addr=%h wd=%h want we=1 addr=%h wd=%h",
                                   i, ram_we, ram_addr, ram_wdata, 10'h020 + 10'(i), 13'h0100 + 13'(i));
            end
        end
        n_chk++;
        if ({in_ready, q_level} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL bp_empty got rdy=%0b lvl=%0d want rdy=1 lvl=0", in_ready, q_level);
        end
        tick;
        n_chk++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL bp_fifth_dropped got we=%0b want 0", ram_we);
        end
    endtask

    task automatic test_fill;
        in_valid = 1'b1;
        in_vec   = {2'b10, 10'h3FC, 13'h0155};
        tick;
        in_valid = 1'b0;
        n_chk++;
        if ({fill_active, busy, q_level} !== {1'b0, 1'b1, 3'd1}) begin
            n_fail++; $display("FAIL fill_pushed got fa=%0b busy=%0b lvl=%0d want fa=0 busy=1 lvl=1", fill_active, busy, q_level);
        end
        tick;
        n_chk++;
        if ({fill_active, ram_we} !== 2'b10) begin
            n_fail++; $display("FAIL fill_enter got fa=%0b we=%0b want fa=1 we=0", fill_active, ram_we);
        end
        tick;
        n_chk++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h3FC, 13'h0155}) begin
            n_fail++; $display("FAIL fill_first got we=%0b addr=%h wd=%h want we=1 addr=3fc wd=0155", ram_we, ram_addr, ram_wdata);
        end
        rd_en   = 1'b1;
        rd_addr = 10'h123;
        tick;
        rd_en = 1'b0;
        n_chk++;
        if ({ram_we, ram_addr, fill_active} !== {1'b0, 10'h123, 1'b1}) begin
            n_fail++; $display("FAIL fill_read_stall got we=%0b addr=%h fa=%0b want we=0 addr=123 fa=1", ram_we, ram_addr, fill_active);
        end
        for (int j = 0; j < 3; j++) begin
            tick;
            n_chk++;
            if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h3FD + 10'(j), 13'h0155}) begin
                n_fail++; $display("FAIL fill_resume%0d got we=%0b addr=%h wd=%h want we=1 addr=%h wd=0155",
                                   j, ram_we, ram_addr, ram_wdata, 10'h3FD + 10'(j));
            end
        end
        n_chk++;
        if ({fill_active, busy, q_level} !== {1'b0, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL fill_done got fa=%0b busy=%0b lvl=%0d want all 0", fill_active, busy, q_level);
        end
        // single-address fill at the end boundary
        in_valid = 1'b1;
        in_vec   = {2'b10, 10'h3FF, 13'h1E1E};
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        n_chk++;
        if ({ram_we, ram_addr, ram_wdata, fill_active} !== {1'b1, 10'h3FF, 13'h1E1E, 1'b0}) begin
            n_fail++; $display("FAIL fill_end_single got we=%0b addr=%h wd=%h fa=%0b want we=1 addr=3ff wd=1e1e fa=0",
                               ram_we, ram_addr, ram_wdata, fill_active);
        end
        tick;
        n_chk++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL fill_end_once got we=%0b want 0", ram_we);
        end
    endtask

    task automatic test_blank;
        wr_blank_only = 1'b1;
        vblank        = 1'b0;
        in_valid      = 1'b1;
        in_vec        = {2'b01, 10'h0AA, 13'h1111};
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++;
            if ({ram_we, busy} !== 2'b01) begin
                n_fail++; $display("FAIL blank_hold%0d got we=%0b busy=%0b want we=0 busy=1", i, ram_we, busy);
            end
        end
        vblank  = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 10'h000;
        tick;
        rd_en = 1'b0;
        n_chk++;
        if (ram_we !== 1'b0) begin
            n_fail++; $display("FAIL blank_read_wins got we=%0b want 0", ram_we);
        end
        tick;
        n_chk++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 10'h0AA, 13'h1111}) begin
            n_fail++; $display("FAIL blank_issue got we=%0b addr=%h wd=%h want we=1 addr=0aa wd=1111", ram_we, ram_addr, ram_wdata);
        end
        wr_blank_only = 1'b0;
        vblank        = 1'b0;
    endtask

    task automatic test_noop;
        in_valid = 1'b1;
        in_vec   = {2'b00, 10'h333, 13'h1FFF};
        tick;
        in_vec = {2'b01, 10'h010, 13'h0777};
        tick;
        in_valid = 1'b0;
        n_chk++;
        if ({ram_we, q_level} !== {1'b0, 3'd1}) begin
            n_fail++; $display("FAIL noop_consume got we=%0b lvl=%0d want we=0 lvl=1", ram_we, q_level);
        end
        tick;
        n_chk++;
        if ({ram_we, ram_addr, ram_wdata, q_level} !== {1'b1, 10'h010, 13'h0777, 3'd0}) begin
            n_fail++; $display("FAIL noop_then_write got we=%0b addr=%h wd=%h lvl=%0d want we=1 addr=010 wd=0777 lvl=0",
                               ram_we, ram_addr, ram_wdata, q_level);
        end
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1;
        in_vec   = {2'b10, 10'h200, 13'h0F0F};
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        n_chk++;
        if ({fill_active, ram_we, ram_addr} !== {1'b1, 1'b1, 10'h201}) begin
            n_fail++; $display("FAIL rmid_filling got fa=%0b we=%0b addr=%h want fa=1 we=1 addr=201", fill_active, ram_we, ram_addr);
        end
        #3;
        nVRST = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, ram_we, busy, fill_active, q_level, ram_addr, ram_wdata} !== '0) begin
            n_fail++; $display("FAIL rmid_async got rdy=%0b we=%0b busy=%0b fa=%0b lvl=%0d addr=%h wd=%h want all 0",
                               in_ready, ram_we, busy, fill_active, q_level, ram_addr, ram_wdata);
        end
        tick;
        nVRST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            n_chk++;
            if ({ram_we, busy, fill_active} !== 3'b000) begin
                n_fail++; $display("FAIL rmid_quiet%0d got we=%0b busy=%0b fa=%0b want all 0", i, ram_we, busy, fill_active);
            end
        end
    endtask

    task automatic test_random;
        wr_t        exp_q[$];
        wr_t        e;
        logic [1:0] c;
        logic [9:0] a, rda;
        logic [12:0] d;
        logic       acc, rde, slot;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            c = 2'($urandom);
            a = (c == 2'b10) ? 10'h3F0 + 10'($urandom % 16) : 10'($urandom);
            d = 13'($urandom);
            in_valid = ($urandom % 3 == 0);
            in_vec   = {c, a, d};
            rd_en    = ($urandom % 4 == 0);
            rd_addr  = 10'($urandom);
            if (cyc % 500 == 0) wr_blank_only = 1'($urandom);
            vblank   = ($urandom % 3 != 0);
            #1;
            acc  = in_valid & in_ready;
            rde  = rd_en;
            rda  = rd_addr;
            slot = !rd_en && (!wr_blank_only || vblank);
            if (acc) begin
                if (c == 2'b10) begin
                    for (int x = int'(a); x <= 1023; x++) exp_q.push_back({10'(x), d});
                end else if (c != 2'b00) begin
                    exp_q.push_back({a, d});
                end
            end
            tick;
            if (rde) begin
                n_chk++;
                if ({ram_we, ram_addr} !== {1'b0, rda}) begin
                    n_fail++; $display("FAIL rnd_read cyc%0d got we=%0b addr=%h want we=0 addr=%h", cyc, ram_we, ram_addr, rda);
                end
            end else if (!slot) begin
                n_chk++;
                if (ram_we !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_noslot cyc%0d got we=%0b want 0", cyc, ram_we);
                end
            end else if (ram_we === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra_write cyc%0d got addr=%h want no write", cyc, ram_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({ram_addr, ram_wdata} !== e) begin
                        n_fail++; $display("FAIL rnd_write cyc%0d got addr=%h wd=%h want addr=%h wd=%h",
                                           cyc, ram_addr, ram_wdata, e.a, e.d);
                    end
                end
            end
        end
        in_valid      = 1'b0;
        rd_en         = 1'b0;
        wr_blank_only = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick;
            if (ram_we === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_drain_extra got addr=%h want no write", ram_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({ram_addr, ram_wdata} !== e) begin
                        n_fail++; $display("FAIL rnd_drain_write got addr=%h wd=%h want addr=%h wd=%h",
                                           ram_addr, ram_wdata, e.a, e.d);
                    end
                end
            end
            if (busy === 1'b0) break;
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain_timeout got busy=%0b want 0", busy);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rnd_missing got %0d pending writes want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_fill;
        test_blank;
        test_noop;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/osd_wr_scheduler.md
# osd_wr_scheduler

- Sits in the VCLK domain between the resynchronised OSD write stream and the single-port OSD text RAM.
- Buffers OSD write commands in a small FIFO and expands fill commands into per-address writes.
- Shares the RAM address port with the OSD renderer's read requests; renderer reads always win, and writes go only into idle slots, optionally restricted to vertical blanking.

## Interface

Parameters:
- QDEPTH_LOG2, default 2: command queue depth is 2^QDEPTH_LOG2 entries.
- FILL_END, default 10'h3FF: last address written by a fill command.

Ports:
- VCLK  in  1  video clock; all logic on its rising edge.
- nVRST  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream command valid.
- in_ready  out  1  queue can accept a command; equals ~full.
- in_vec  in  25  command {ctrl[1:0], addr[9:0], data[12:0]}.
- rd_en  in  1  renderer read request this cycle.
- rd_addr  in  10  renderer read address.
- wr_blank_only  in  1  1: writes allowed only while vblank=1.
- vblank  in  1  vertical blanking indicator, VCLK-synchronous.
- ram_addr  out  10  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  13  registered RAM write data.
- busy  out  1  queue non-empty or fill in progress.
- fill_active  out  1  state is FILL.
- q_level  out  QDEPTH_LOG2+1  current queue occupancy.

## Operation

**Queue**
- Circular FIFO of 25-bit entries with wrapping read/write pointers and an occupancy counter.
- Push when in_valid & in_ready.
- in_ready is derived only from the registered count, never from a same-cycle pop. When full, no push occurs even if a pop happens that cycle.
- Simultaneous push and pop when not full: count unchanged.

**Command decode (ctrl)**
- 2'b00: no-op. Popped in one cycle, no RAM access, no slot needed.
- 2'b01: single write of data to addr.
- 2'b10: fill. Writes data to every address from addr to FILL_END inclusive, ascending.
  - If addr > FILL_END, performs one write at addr, then ends.
- 2'b11: reserved; handled exactly as 2'b01.

**Write slot**
- wr_slot = ~rd_en & (~wr_blank_only | vblank).

**States**
- IDLE
  - If the queue is non-empty and the head is a fill, load fill_ptr ← head.addr and go to FILL. No write is issued in the cycle the state changes.
  - Otherwise, a write or no-op head is issued/popped when wr_slot is high.
- FILL
  - Each wr_slot cycle writes fill_ptr.
  - If fill_ptr == FILL_END or the start was > FILL_END: pop the head and go to IDLE.
  - Otherwise increment fill_ptr.
  - Cycles without a slot stall with fill_ptr held.

**RAM port update, per edge (priority order)**
1. rd_en=1: ram_addr ← rd_addr, ram_we ← 0.
2. Else, a write is issued: ram_addr ← target, ram_wdata ← data, ram_we ← 1.
3. Else: ram_we ← 0; ram_addr and ram_wdata hold.

**Status**
- busy = (count≠0) | fill_active.
- fill_active = (state==FILL).

## Timing

- Reset values:
  - in_ready=0 while nVRST=0, 1 on the first edge after release.
  - ram_addr=0, ram_we=0, ram_wdata=0, busy=0, fill_active=0, q_level=0.
  - State IDLE, pointers 0, fill_ptr 0.
- Reset mid-operation: the queue is discarded and a fill is aborted immediately. No partial state survives.
- Read latency: rd_en/rd_addr sampled at edge k appear on ram_addr at edge k (registered output valid after k). A read is never delayed by a write.
- Write latency, empty queue, continuous slots:
  - Single write: command sampled at edge k is pushed at k, issued at k+1 (ram_we=1 after k+1), and popped at k+1.
  - Fill from address A: FILL entered at k+1; first write at k+2; last write at k+2+(FILL_END−A), assuming all slots free.
- Pop and push occur on the same edge as the corresponding handshake/write. q_level reflects the post-edge count.
- Throughput: at most one RAM write per VCLK. With rd_en constantly high, the queue fills and in_ready drops after 2^QDEPTH_LOG2 accepted commands.

## Test plan

1. Reset release, rd_en=0, wr_blank_only=0. Push {01, 10'h005, 13'h0ABC} -> ram_we=1, ram_addr=5, ram_wdata=0ABC exactly one cycle, one edge after the push. busy back to 0 on the same edge.
2. rd_en=1 constantly, push 5 writes -> 4 accepted, in_ready=0, q_level=4, ram_we never 1. Drop rd_en -> 4 writes on consecutive cycles in push order, then in_ready=1.
3. Fill {10, 10'h3FC, 13'h0000} -> fill_active for 5 cycles, writes at 3FC, 3FD, 3FE, 3FF. Toggle rd_en mid-fill -> read addresses are passed through and fill resumes at the held fill_ptr.
4. wr_blank_only=1, vblank=0, push write -> no ram_we until vblank=1. Write issues on the first edge with vblank=1 & rd_en=0.
5. Push no-op {00,…} followed by write to 10'h010 -> no-op consumes one cycle with ram_we=0; write appears the next cycle.
6. Assert nVRST low during a fill at 10'h200 -> outputs go to reset values asynchronously. After release, busy=0 and no further writes occur.
